// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// dcache_pkg : shared types, default geometry and address-field helper
// Rev 1.0
// ============================================================================
package dcache_pkg;

  localparam int TAG_W_DEF = 3;
  localparam int IDX_W_DEF = 10;
  localparam int OFF_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_RESP   = 3'd2,
    S_WB_RD  = 3'd3,
    S_WB_MEM = 3'd4,
    S_REFILL = 3'd5
  } state_e;

  // Generic field extractor so tag/idx/off follow whatever geometry is chosen.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tagstore.sv
`default_nettype none
// ============================================================================
// dcache_tagstore : per-line tag/valid/dirty storage, one lookup/update port
// Rev 1.0
// ============================================================================
module dcache_tagstore #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             valid_o,
  output logic             dirty_o,
  input  logic             upd_en_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic             upd_valid_i,
  input  logic             upd_dirty_i
);

  localparam int LINES = 1 << IDX_W;

  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (upd_en_i) begin
      valid_q[idx_i] <= upd_valid_i;
      dirty_q[idx_i] <= upd_dirty_i;
    end
  end

  // Tags need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (upd_en_i) tag_q[idx_i] <= upd_tag_i;
  end

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_ctrl : direct-mapped write-back/write-allocate data cache controller
// Optional macro DCACHE_STATS_EN adds stat_hits_o / stat_misses_o counters.
// Rev 1.0
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req_i,
  input  logic                         cpu_we_i,
  input  logic [TAG_W+IDX_W+OFF_W-1:0] cpu_addr_i,
  input  logic [31:0]                  cpu_wdata_i,
  output logic                         cpu_ack_o,
  output logic [31:0]                  cpu_rdata_o,
  output logic [IDX_W+OFF_W-1:0]       da_addr_o,
  output logic                         da_we_o,
  output logic [31:0]                  da_wdata_o,
  input  logic [31:0]                  da_rdata_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [TAG_W+IDX_W+OFF_W-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [31:0]                  mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                  stat_hits_o,
  output logic [31:0]                  stat_misses_o
`endif
);

  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] K_LAST = {OFF_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [OFF_W-1:0]  k_q;
  logic              rd_ph_q;
  logic              replay_q;
  logic [TAG_W-1:0]  old_tag_q;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_k_nxt;
  logic [TAG_W-1:0]  w_ts_tag;
  logic              w_ts_valid;
  logic              w_ts_dirty;
  logic              w_hit;
  logic              w_upd_en;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_valid;
  logic              w_upd_dirty;

  assign w_tag   = TAG_W'(addr_field(32'(addr_q), IDX_W + OFF_W, TAG_W));
  assign w_idx   = IDX_W'(addr_field(32'(addr_q), OFF_W, IDX_W));
  assign w_off   = OFF_W'(addr_field(32'(addr_q), 0, OFF_W));
  assign w_k_nxt = k_q + 1'b1;
  assign w_hit   = w_ts_valid && (w_ts_tag == w_tag);

  dcache_tagstore #(
    .TAG_W(TAG_W),
    .IDX_W(IDX_W)
  ) u_tagstore (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_i      (w_idx),
    .tag_o      (w_ts_tag),
    .valid_o    (w_ts_valid),
    .dirty_o    (w_ts_dirty),
    .upd_en_i   (w_upd_en),
    .upd_tag_i  (w_upd_tag),
    .upd_valid_i(w_upd_valid),
    .upd_dirty_i(w_upd_dirty)
  );

  always_comb begin
    w_upd_en    = 1'b0;
    w_upd_tag   = w_ts_tag;
    w_upd_valid = w_ts_valid;
    w_upd_dirty = w_ts_dirty;
    if (state_q == S_LOOKUP && !da_we_o && w_hit && we_q) begin
      w_upd_en    = 1'b1;
      w_upd_dirty = 1'b1;
    end
    if (state_q == S_WB_MEM && mem_ack_i && k_q == K_LAST) begin
      w_upd_en    = 1'b1;
      w_upd_dirty = 1'b0;
    end
    if (state_q == S_REFILL && mem_ack_i && k_q == K_LAST) begin
      w_upd_en    = 1'b1;
      w_upd_tag   = w_tag;
      w_upd_valid = 1'b1;
      w_upd_dirty = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      k_q         <= '0;
      rd_ph_q     <= 1'b0;
      replay_q    <= 1'b0;
      old_tag_q   <= '0;
      cpu_ack_o   <= 1'b0;
      cpu_rdata_o <= '0;
      da_addr_o   <= '0;
      da_we_o     <= 1'b0;
      da_wdata_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
`ifdef DCACHE_STATS_EN
      stat_hits_o   <= '0;
      stat_misses_o <= '0;
`endif
    end else begin
      cpu_ack_o <= 1'b0;
      da_we_o   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i) begin
            addr_q    <= cpu_addr_i;
            we_q      <= cpu_we_i;
            wdata_q   <= cpu_wdata_i;
            da_addr_o <= cpu_addr_i[IDX_W+OFF_W-1:0];
            replay_q  <= 1'b0;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // First replay cycle: last refill word is still being written, so re-aim the array.
          if (da_we_o) begin
            da_addr_o <= {w_idx, w_off};
          end else begin
`ifdef DCACHE_STATS_EN
            if (!replay_q) begin
              if (w_hit) stat_hits_o   <= stat_hits_o + 32'd1;
              else       stat_misses_o <= stat_misses_o + 32'd1;
            end
`endif
            if (w_hit) begin
              if (we_q) begin
                da_we_o    <= 1'b1;
                da_wdata_o <= wdata_q;
              end
              state_q <= S_RESP;
            end else begin
              k_q       <= '0;
              old_tag_q <= w_ts_tag;
              if (w_ts_valid && w_ts_dirty) begin
                da_addr_o <= {w_idx, {OFF_W{1'b0}}};
                rd_ph_q   <= 1'b0;
                state_q   <= S_WB_RD;
              end else begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= {w_tag, w_idx, {OFF_W{1'b0}}};
                state_q    <= S_REFILL;
              end
            end
          end
        end
        S_RESP: begin
          cpu_ack_o <= 1'b1;
          if (!we_q) cpu_rdata_o <= da_rdata_i;
          state_q <= S_IDLE;
        end
        S_WB_RD: begin
          // Two cycles: present the word address, then capture the array output.
          if (!rd_ph_q) begin
            rd_ph_q <= 1'b1;
          end else begin
            rd_ph_q     <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= {old_tag_q, w_idx, k_q};
            mem_wdata_o <= da_rdata_i;
            state_q     <= S_WB_MEM;
          end
        end
        S_WB_MEM: begin
          if (mem_ack_i) begin
            mem_we_o <= 1'b0;
            if (k_q == K_LAST) begin
              k_q        <= '0;
              mem_addr_o <= {w_tag, w_idx, {OFF_W{1'b0}}};
              state_q    <= S_REFILL;
            end else begin
              mem_req_o <= 1'b0;
              k_q       <= w_k_nxt;
              da_addr_o <= {w_idx, w_k_nxt};
              state_q   <= S_WB_RD;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            da_we_o    <= 1'b1;
            da_addr_o  <= {w_idx, k_q};
            da_wdata_o <= mem_rdata_i;
            if (k_q == K_LAST) begin
              mem_req_o <= 1'b0;
              k_q       <= '0;
              replay_q  <= 1'b1;
              state_q   <= S_LOOKUP;
            end else begin
              k_q        <= w_k_nxt;
              mem_addr_o <= {w_tag, w_idx, w_k_nxt};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dcache_ctrl : directed self-checking bench for dcache_ctrl
// Rev 1.0
// ============================================================================
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [13:0] da_addr;
  logic        da_we;
  logic [31:0] da_wdata;
  logic [31:0] da_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_rdata_o(cpu_rdata),
    .da_addr_o  (da_addr),
    .da_we_o    (da_we),
    .da_wdata_o (da_wdata),
    .da_rdata_i (da_rdata),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits_o  (stat_hits),
    .stat_misses_o(stat_misses)
`endif
  );

  // External data array: synchronous write, one-cycle read latency.
  logic [31:0] da_mem [0:16383];
  always @(posedge clk) begin
    if (da_we) da_mem[da_addr] <= da_wdata;
    da_rdata <= da_mem[da_addr];
  end

  // Main memory: unwritten words read as 0xA0 + offset + (tag << 16).
  function automatic logic [31:0] mem_default(input logic [16:0] a);
    return 32'hA0 + 32'(a[3:0]) + (32'(a[16:14]) << 16);
  endfunction

  logic [31:0] wr_mem [int];
  int          mem_dly = 0;
  int          cnt;
  int          rf_cnt = 0;
  logic [16:0] rf_addr_q [$];
  logic [16:0] wb_addr_q [$];
  logic [31:0] wb_data_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack <= 1'b0;
      cnt     <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (cnt >= mem_dly) begin
          mem_ack <= 1'b1;
          cnt     <= 0;
          if (mem_we) begin
            wr_mem[int'(mem_addr)] = mem_wdata;
            wb_addr_q.push_back(mem_addr);
            wb_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata <= wr_mem.exists(int'(mem_addr)) ? wr_mem[int'(mem_addr)]
                                                       : mem_default(mem_addr);
            rf_addr_q.push_back(mem_addr);
            rf_cnt <= rf_cnt + 1;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Request-hold monitor: address/data/direction must not move before ack.
  int          unstable = 0;
  int          req_cycles = 0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [16:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) req_cycles <= req_cycles + 1;
      if (p_req && !p_ack && mem_req &&
          (mem_addr != p_addr || mem_we != p_we || (mem_we && mem_wdata != p_wdata)))
        unstable <= unstable + 1;
    end
    p_req   <= mem_req && rst_n;
    p_ack   <= mem_ack;
    p_we    <= mem_we;
    p_addr  <= mem_addr;
    p_wdata <= mem_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [16:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 0;
    while (!cpu_ack && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    rd = cpu_rdata;
    check_eq({tag, "_ack_seen"}, 32'(cpu_ack), 32'd1);
  endtask

  logic [31:0] rd;
  int          lat;
  int          b_rf, b_wb, b_req;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_da_we", 32'(da_we), 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    rst_n = 1'b1;

    // Cold read miss: clean refill of line idx 1.
    b_rf = rf_cnt; b_wb = wb_addr_q.size();
    cpu_access("miss0", 1'b0, 17'h00010, 32'd0, rd, lat);
    check_eq("miss0_rdata", rd, 32'h000000A0);
    check_eq("miss0_refills", 32'(rf_cnt - b_rf), 32'd16);
    check_eq("miss0_wbs", 32'(wb_addr_q.size() - b_wb), 32'd0);
    check_eq("miss0_rf_last_addr", 32'(rf_addr_q[b_rf + 15]), 32'h0001F);
    check_eq("miss0_da_word15", da_mem[14'h01F], 32'h000000AF);
`ifdef DCACHE_STATS_EN
    check_eq("miss0_stat_misses", stat_misses, 32'd1);
    check_eq("miss0_stat_hits", stat_hits, 32'd0);
`endif

    // Write hit then read hit: two-cycle latency, no memory traffic.
    b_req = req_cycles;
    cpu_access("whit", 1'b1, 17'h00010, 32'hDEADBEEF, rd, lat);
    check_eq("whit_latency", 32'(lat), 32'd2);
    check_eq("whit_da_word0", da_mem[14'h010], 32'hDEADBEEF);
    cpu_access("rhit", 1'b0, 17'h00015, 32'd0, rd, lat);
    check_eq("rhit_latency", 32'(lat), 32'd2);
    check_eq("rhit_rdata", rd, 32'h000000A5);
    check_eq("hit_no_mem_req", 32'(req_cycles - b_req), 32'd0);
`ifdef DCACHE_STATS_EN
    check_eq("hit_stat_hits", stat_hits, 32'd2);
`endif

    // Conflict miss on a dirty line, slow memory: write-back then refill.
    mem_dly = 5;
    b_rf = rf_cnt; b_wb = wb_addr_q.size();
    cpu_access("evict", 1'b0, 17'h04010, 32'd0, rd, lat);
    check_eq("evict_wbs", 32'(wb_addr_q.size() - b_wb), 32'd16);
    check_eq("evict_wb0_addr", 32'(wb_addr_q[b_wb]), 32'h00010);
    check_eq("evict_wb0_data", wb_data_q[b_wb], 32'hDEADBEEF);
    check_eq("evict_wb5_data", wb_data_q[b_wb + 5], 32'h000000A5);
    check_eq("evict_wb15_addr", 32'(wb_addr_q[b_wb + 15]), 32'h0001F);
    check_eq("evict_refills", 32'(rf_cnt - b_rf), 32'd16);
    check_eq("evict_rf0_addr", 32'(rf_addr_q[b_rf]), 32'h04010);
    check_eq("evict_rdata", rd, 32'h000100A0);
    check_eq("evict_req_stable", 32'(unstable), 32'd0);

    // Old line comes back from memory carrying the written-back data.
    mem_dly = 2;
    b_rf = rf_cnt; b_wb = wb_addr_q.size();
    cpu_access("back", 1'b0, 17'h00010, 32'd0, rd, lat);
    check_eq("back_rdata", rd, 32'hDEADBEEF);
    check_eq("back_wbs_clean", 32'(wb_addr_q.size() - b_wb), 32'd0);
    check_eq("back_refills", 32'(rf_cnt - b_rf), 32'd16);
`ifdef DCACHE_STATS_EN
    check_eq("back_stat_misses", stat_misses, 32'd3);
`endif

    // Reset in the middle of a refill, at word 7.
    mem_dly = 3;
    b_rf = rf_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h04020;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 500 && (rf_cnt - b_rf) < 7; i++) @(negedge clk);
    check_eq("rstmid_reached_k7", 32'(rf_cnt - b_rf), 32'd7);
    @(negedge clk);
    check_eq("rstmid_req_before", 32'(mem_req), 32'd1);
    check_eq("rstmid_addr_k7", 32'(mem_addr), 32'h04027);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_req_dropped", 32'(mem_req), 32'd0);
    check_eq("rstmid_ack_low", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_rf = rf_cnt;
    cpu_access("after_rst", 1'b0, 17'h04020, 32'd0, rd, lat);
    check_eq("after_rst_refills", 32'(rf_cnt - b_rf), 32'd16);
    check_eq("after_rst_rdata", rd, 32'h000100A0);
    b_rf = rf_cnt;
    cpu_access("after_rst2", 1'b0, 17'h00015, 32'd0, rd, lat);
    check_eq("after_rst2_refills", 32'(rf_cnt - b_rf), 32'd16);
    check_eq("after_rst2_rdata", rd, 32'h000000A5);
`ifdef DCACHE_STATS_EN
    check_eq("after_rst_stat_misses", stat_misses, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
